// File: rtl/draw_text_box.sv
// rtl/draw_text_box.sv - text-box glyph overlay on a VGA pixel stream, 4-cycle pipeline
module draw_text_box #(
    parameter logic [10:0] XPOS  = 11'd0,
    parameter logic [10:0] YPOS  = 11'd0,
    parameter int          COLS  = 16,
    parameter int          ROWS  = 16,
    parameter logic [11:0] COLOR = 12'hFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [10:0] hcount_in,
    input  logic [10:0] vcount_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        hblnk_in,
    input  logic        vblnk_in,
    input  logic [11:0] rgb_in,
    input  logic [7:0]  char_pixels,
    output logic [7:0]  char_xy,
    output logic [3:0]  char_line,
    output logic [10:0] hcount_out,
    output logic [10:0] vcount_out,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        hblnk_out,
    output logic        vblnk_out,
    output logic [11:0] rgb_out
);

    localparam logic [10:0] BOX_W = 11'(8 * COLS);
    localparam logic [10:0] BOX_H = 11'(16 * ROWS);

    // Everything that must travel alongside a pixel until it is composited.
    typedef struct packed {
        logic [10:0] hcount;
        logic [10:0] vcount;
        logic        hsync;
        logic        vsync;
        logic        hblnk;
        logic        vblnk;
        logic [11:0] rgb;
        logic        flag;
        logic [2:0]  dx;
    } pix_t;

    logic [11:0] dx_ext;
    logic [11:0] dy_ext;
    logic        in_box;
    pix_t        s0;
    pix_t        d1;
    pix_t        d2;
    pix_t        d3;

    // Offsets are taken one bit wider so the borrow bit rejects pixels left of / above the box.
    always_comb begin
        dx_ext = {1'b0, hcount_in} - {1'b0, XPOS};
        dy_ext = {1'b0, vcount_in} - {1'b0, YPOS};
        in_box = !dx_ext[11] && (dx_ext[10:0] < BOX_W) &&
                 !dy_ext[11] && (dy_ext[10:0] < BOX_H);
        s0.hcount = hcount_in;
        s0.vcount = vcount_in;
        s0.hsync  = hsync_in;
        s0.vsync  = vsync_in;
        s0.hblnk  = hblnk_in;
        s0.vblnk  = vblnk_in;
        s0.rgb    = rgb_in;
        s0.flag   = in_box & en;
        s0.dx     = dx_ext[2:0];
    end

    // Stage 1: cell address and glyph row go out to the character buffer and font ROM.
    always_ff @(posedge clk) begin
        if (rst) begin
            char_xy   <= 8'h00;
            char_line <= 4'h0;
        end else if (in_box) begin
            char_xy   <= {dy_ext[7:4], dx_ext[6:3]};
            char_line <= dy_ext[3:0];
        end else begin
            char_xy   <= 8'h00;
            char_line <= 4'h0;
        end
    end

    // Stages 1-3: carry the pixel through the same latency as the external lookup.
    always_ff @(posedge clk) begin
        if (rst) begin
            d1 <= '0;
            d2 <= '0;
            d3 <= '0;
        end else begin
            d1 <= s0;
            d2 <= d1;
            d3 <= d2;
        end
    end

    // Stage 4: composite the glyph bit that arrived from the ROM this cycle; blanking forces black.
    always_ff @(posedge clk) begin
        if (rst) begin
            hcount_out <= 11'd0;
            vcount_out <= 11'd0;
            hsync_out  <= 1'b0;
            vsync_out  <= 1'b0;
            hblnk_out  <= 1'b0;
            vblnk_out  <= 1'b0;
            rgb_out    <= 12'h000;
        end else begin
            hcount_out <= d3.hcount;
            vcount_out <= d3.vcount;
            hsync_out  <= d3.hsync;
            vsync_out  <= d3.vsync;
            hblnk_out  <= d3.hblnk;
            vblnk_out  <= d3.vblnk;
            if (d3.hblnk || d3.vblnk)
                rgb_out <= 12'h000;
            else if (d3.flag && char_pixels[3'd7 - d3.dx])
                rgb_out <= COLOR;
            else
                rgb_out <= d3.rgb;
        end
    end

endmodule

// File: tb/tb_draw_text_box.sv
// tb/tb_draw_text_box.sv - randomized and directed check of draw_text_box against a pixel-history model
module tb_draw_text_box;

    localparam logic [10:0] XP = 11'd100;
    localparam logic [10:0] YP = 11'd200;
    localparam int          NC = 5;
    localparam int          NR = 3;
    localparam logic [11:0] FG = 12'hABC;
    localparam int          N  = 1200;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [10:0] hcount_in = '0;
    logic [10:0] vcount_in = '0;
    logic        hsync_in = 1'b0;
    logic        vsync_in = 1'b0;
    logic        hblnk_in = 1'b0;
    logic        vblnk_in = 1'b0;
    logic [11:0] rgb_in = '0;
    logic [7:0]  char_pixels = '0;
    logic [7:0]  char_xy;
    logic [3:0]  char_line;
    logic [10:0] hcount_out;
    logic [10:0] vcount_out;
    logic        hsync_out;
    logic        vsync_out;
    logic        hblnk_out;
    logic        vblnk_out;
    logic [11:0] rgb_out;

    draw_text_box #(.XPOS(XP), .YPOS(YP), .COLS(NC), .ROWS(NR), .COLOR(FG)) dut (
        .clk(clk), .rst(rst), .en(en),
        .hcount_in(hcount_in), .vcount_in(vcount_in),
        .hsync_in(hsync_in), .vsync_in(vsync_in),
        .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
        .rgb_in(rgb_in), .char_pixels(char_pixels),
        .char_xy(char_xy), .char_line(char_line),
        .hcount_out(hcount_out), .vcount_out(vcount_out),
        .hsync_out(hsync_out), .vsync_out(vsync_out),
        .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
        .rgb_out(rgb_out)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int k = 0;

    int h_h[N];
    int v_h[N];
    int rgb_h[N];
    int gl_h[N];
    bit hs_h[N];
    bit vs_h[N];
    bit hb_h[N];
    bit vb_h[N];
    bit en_h[N];
    bit rst_h[N];

    function automatic bit box(input int h, input int v);
        return (h >= int'(XP)) && (h < int'(XP) + 8 * NC) &&
               (v >= int'(YP)) && (v < int'(YP) + 16 * NR);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, k, obs, exp);
        end
    endtask

    // Compare every output against what the pixel history says it must be this cycle.
    task automatic verify();
        int pc;
        int po;
        int exy;
        int eln;
        int ergb;
        int g;
        int dxm;
        bit z;
        pc = k - 1;
        exy = 0;
        eln = 0;
        if (!rst_h[pc] && box(h_h[pc], v_h[pc])) begin
            exy = ((v_h[pc] - int'(YP)) / 16) * 16 + (h_h[pc] - int'(XP)) / 8;
            eln = (v_h[pc] - int'(YP)) % 16;
        end
        check("char_xy", 32'(char_xy), 32'(exy));
        check("char_line", 32'(char_line), 32'(eln));

        po = k - 4;
        z = (po < 0);
        for (int j = (po < 0 ? 0 : po); j < k; j++)
            if (rst_h[j]) z = 1'b1;
        if (z) begin
            check("hcount_out", 32'(hcount_out), 0);
            check("vcount_out", 32'(vcount_out), 0);
            check("sync_blank_out", 32'({hsync_out, vsync_out, hblnk_out, vblnk_out}), 0);
            check("rgb_out", 32'(rgb_out), 0);
        end else begin
            if (hb_h[po] || vb_h[po]) begin
                ergb = 0;
            end else begin
                ergb = rgb_h[po];
                if (en_h[po] && box(h_h[po], v_h[po])) begin
                    g = gl_h[po];
                    dxm = (h_h[po] - int'(XP)) % 8;
                    if (g[7 - dxm]) ergb = int'(FG);
                end
            end
            check("hcount_out", 32'(hcount_out), 32'(h_h[po]));
            check("vcount_out", 32'(vcount_out), 32'(v_h[po]));
            check("hsync_out", 32'(hsync_out), 32'(hs_h[po]));
            check("vsync_out", 32'(vsync_out), 32'(vs_h[po]));
            check("hblnk_out", 32'(hblnk_out), 32'(hb_h[po]));
            check("vblnk_out", 32'(vblnk_out), 32'(vb_h[po]));
            check("rgb_out", 32'(rgb_out), 32'(ergb));
        end
    endtask

    // Present one pixel (and the ROM byte for the pixel three cycles back), clock it, then check.
    task automatic step(input int h, input int v, input bit hs, input bit vs, input bit hb,
                        input bit vb, input bit e, input bit r, input int rgb, input int gl);
        int g3;
        h_h[k] = h; v_h[k] = v; hs_h[k] = hs; vs_h[k] = vs; hb_h[k] = hb; vb_h[k] = vb;
        en_h[k] = e; rst_h[k] = r; rgb_h[k] = rgb & 12'hFFF; gl_h[k] = gl & 8'hFF;
        hcount_in = 11'(h);
        vcount_in = 11'(v);
        hsync_in = hs; vsync_in = vs; hblnk_in = hb; vblnk_in = vb;
        en = e; rst = r;
        rgb_in = 12'(rgb);
        g3 = (k >= 3) ? gl_h[k - 3] : 0;
        char_pixels = 8'(g3);
        @(posedge clk);
        #1;
        k++;
        verify();
    endtask

    task automatic rand_step(input bit r);
        step(90 + int'($urandom % 60), 195 + int'($urandom % 60),
             bit'($urandom), bit'($urandom), ($urandom % 8) == 0, ($urandom % 12) == 0,
             ($urandom % 4) != 0, r, int'($urandom), int'($urandom));
    endtask

    initial begin
        step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        step(100, 200, 1, 0, 0, 0, 1, 0, 12'h111, 8'h80);
        step(115, 217, 0, 1, 0, 0, 1, 0, 12'h222, 8'h40);
        step(99, 200, 1, 0, 0, 0, 1, 0, 12'h333, 8'hFF);
        step(140, 200, 0, 0, 0, 0, 1, 0, 12'h444, 8'hFF);
        step(139, 247, 1, 1, 0, 0, 1, 0, 12'h555, 8'hFF);
        step(120, 248, 0, 0, 0, 0, 1, 0, 12'h666, 8'hFF);
        for (int d = 0; d < 8; d++)
            step(100 + d, 205, d[0], 0, 0, 0, 1, 0, 12'h123, 8'h81);
        step(100, 205, 1, 0, 1, 0, 1, 0, 12'h777, 8'hFF);
        step(101, 205, 0, 0, 0, 1, 1, 0, 12'h777, 8'hFF);
        step(102, 205, 1, 0, 0, 0, 0, 0, 12'h777, 8'hFF);
        for (int i = 0; i < 400; i++) rand_step(1'b0);
        rand_step(1'b1);
        for (int i = 0; i < 400; i++) rand_step(1'b0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
